// File: rtl/softmax_top1.sv
// Top-1 argmax over the four softmax probabilities: captures on SmDone rise,
// scans one float compare per cycle, and returns index/value on valid/ready.
// Optional SOFTMAX_TOP1_THRESH_EN adds a Thresh input and a Confident output.
module softmax_top1 #(
  parameter int DATALENGTH = 32,
  parameter int INPUTMAX   = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SmDone,
  input  logic [INPUTMAX:0]     N,
  input  logic [DATALENGTH-1:0] Y0,
  input  logic [DATALENGTH-1:0] Y1,
  input  logic [DATALENGTH-1:0] Y2,
  input  logic [DATALENGTH-1:0] Y3,
  input  logic                  Ready,
`ifdef SOFTMAX_TOP1_THRESH_EN
  input  logic [DATALENGTH-1:0] Thresh,
  output logic                  Confident,
`endif
  output logic                  Valid,
  output logic [INPUTMAX-1:0]   Index,
  output logic [DATALENGTH-1:0] MaxVal,
  output logic                  Busy,
  output logic                  Overrun
);
  localparam int DEPTH = 1 << INPUTMAX;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;
  state_t state_q, state_d;

  logic [DEPTH-1:0][DATALENGTH-1:0] v;
  logic [DATALENGTH-1:0]            best;
  logic [INPUTMAX-1:0]              bidx;
  logic [INPUTMAX-1:0]              n_eff;
  logic [INPUTMAX:0]                j;
  logic                             sm_q;

  logic evt, capture, step, finish, release_res, drop;
  logic [INPUTMAX-1:0]   n_clamp;
  logic [DATALENGTH-1:0] cand;
  logic                  cand_gt;

  // Strict IEEE-754 greater-than; NaN never wins, a NaN b loses to any non-NaN a.
  function automatic logic gt(input logic [DATALENGTH-1:0] a,
                              input logic [DATALENGTH-1:0] b);
    logic a_nan, b_nan, a_zero, b_zero;
    logic [DATALENGTH-2:0] am, bm;
    am     = a[DATALENGTH-2:0];
    bm     = b[DATALENGTH-2:0];
    a_nan  = (a[DATALENGTH-2 -: 8] == 8'hFF) && (a[DATALENGTH-10:0] != '0);
    b_nan  = (b[DATALENGTH-2 -: 8] == 8'hFF) && (b[DATALENGTH-10:0] != '0);
    a_zero = (am == '0);
    b_zero = (bm == '0);
    if (a_nan)                       gt = 1'b0;
    else if (b_nan)                  gt = 1'b1;
    else if (a_zero && b_zero)       gt = 1'b0;
    else if (!a[DATALENGTH-1] && b[DATALENGTH-1]) gt = 1'b1;
    else if (a[DATALENGTH-1] && !b[DATALENGTH-1]) gt = 1'b0;
    else if (!a[DATALENGTH-1])       gt = (am > bm);
    else                             gt = (am < bm);
  endfunction

  assign evt     = SmDone & ~sm_q;
  assign n_clamp = (N > (INPUTMAX+1)'(DEPTH-1)) ? INPUTMAX'(DEPTH-1) : N[INPUTMAX-1:0];
  assign cand    = v[j[INPUTMAX-1:0]];
  assign cand_gt = gt(cand, best);

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    release_res = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: if (evt) begin
        capture = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        drop = evt;
        if (j <= {1'b0, n_eff}) step = 1'b1;
        else begin
          finish  = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        // A rising SmDone on the handshake edge is still counted as dropped.
        drop = evt;
        if (Valid && Ready) begin
          release_res = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      sm_q    <= 1'b0;
      v       <= '0;
      best    <= '0;
      bidx    <= '0;
      n_eff   <= '0;
      j       <= '0;
      Valid   <= 1'b0;
      Index   <= '0;
      MaxVal  <= '0;
      Busy    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      sm_q    <= SmDone;
      if (drop) Overrun <= 1'b1;
      if (capture) begin
        v     <= {Y3, Y2, Y1, Y0};
        best  <= Y0;
        bidx  <= '0;
        j     <= (INPUTMAX+1)'(1);
        n_eff <= n_clamp;
        Busy  <= 1'b1;
      end
      if (step) begin
        if (cand_gt) begin
          best <= cand;
          bidx <= j[INPUTMAX-1:0];
        end
        j <= j + 1'b1;
      end
      if (finish) begin
        Index  <= bidx;
        MaxVal <= best;
        Valid  <= 1'b1;
      end
      if (release_res) begin
        Valid <= 1'b0;
        Busy  <= 1'b0;
      end
    end
  end

`ifdef SOFTMAX_TOP1_THRESH_EN
  logic thresh_nan;
  assign thresh_nan = (Thresh[DATALENGTH-2 -: 8] == 8'hFF) && (Thresh[DATALENGTH-10:0] != '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)       Confident <= 1'b0;
    else if (finish) Confident <= !thresh_nan && gt(best, Thresh);
  end
`endif

endmodule

// File: tb/tb_softmax_top1.sv
// Scoreboard bench for softmax_top1: expected results are queued at stimulus
// time and popped when Valid appears; latency, hold, overrun and reset checked.
module tb_softmax_top1;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        SmDone = 1'b0;
  logic [2:0]  N = '0;
  logic [31:0] Y0 = '0, Y1 = '0, Y2 = '0, Y3 = '0;
  logic        Ready = 1'b0;
  logic        Valid;
  logic [1:0]  Index;
  logic [31:0] MaxVal;
  logic        Busy;
  logic        Overrun;
`ifdef SOFTMAX_TOP1_THRESH_EN
  logic [31:0] Thresh = 32'h3E800000;
  logic        Confident;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int e0    = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] val;
    logic        conf;
  } exp_t;
  exp_t sb[$];

  softmax_top1 dut (
    .Clock(Clock), .Reset(Reset), .SmDone(SmDone), .N(N),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Ready(Ready),
`ifdef SOFTMAX_TOP1_THRESH_EN
    .Thresh(Thresh), .Confident(Confident),
`endif
    .Valid(Valid), .Index(Index), .MaxVal(MaxVal), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Drive a one-cycle SmDone pulse; returns after edge E0.
  task automatic start(input logic [2:0] n, input logic [31:0] a, b, c, d);
    N = n; Y0 = a; Y1 = b; Y2 = c; Y3 = d;
    SmDone = 1'b1;
    tick(1);
    e0 = cyc;
    SmDone = 1'b0;
    tests++;
    if (Busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_capture: got %b want 1", Busy);
    end
  endtask

  // Wait for Valid, check latency and scoreboard head, then the handshake.
  task automatic get_result(input string name, input int lat);
    int waited;
    exp_t e;
    waited = 0;
    while (Valid !== 1'b1 && waited < 50) begin
      tick(1);
      waited++;
    end
    tests++;
    if (Valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: Valid never rose", name);
      return;
    end
    if (cyc - e0 !== lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d want %0d", name, cyc - e0, lat);
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_scoreboard: unexpected result", name);
      return;
    end
    e = sb.pop_front();
    if (Index !== e.idx || MaxVal !== e.val) begin
      fails++;
      $display("FAIL %s_result: got idx=%0d val=%h want idx=%0d val=%h",
               name, Index, MaxVal, e.idx, e.val);
    end
`ifdef SOFTMAX_TOP1_THRESH_EN
    tests++;
    if (Confident !== e.conf) begin
      fails++;
      $display("FAIL %s_confident: got %b want %b", name, Confident, e.conf);
    end
`endif
    if (Ready) begin
      tick(1);
      tests++;
      if (Valid !== 1'b0 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL %s_release: got valid=%b busy=%b want 0 0", name, Valid, Busy);
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick(2);
    tests++;
    if ({Valid, Index, MaxVal, Busy, Overrun} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%b i=%0d m=%h b=%b o=%b want all 0",
               Valid, Index, MaxVal, Busy, Overrun);
    end
    Reset = 1'b0;
    tick(2);
    tests++;
    if ({Valid, Busy, Overrun} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release: got v=%b b=%b o=%b want 0", Valid, Busy, Overrun);
    end
  endtask

  task automatic test_basic;
    Ready = 1'b1;
    sb.push_back('{idx: 2'd1, val: 32'h3ECCCCCD, conf: 1'b1});
    start(3'd3, 32'h3DCCCCCD, 32'h3ECCCCCD, 32'h3E4CCCCD, 32'h3E99999A);
    get_result("basic", 4);
  endtask

  task automatic test_tie_clamp;
    Ready = 1'b1;
    sb.push_back('{idx: 2'd0, val: 32'h3E800000, conf: 1'b0});
    start(3'd2, 32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000);
    get_result("tie_n2", 3);
    sb.push_back('{idx: 2'd0, val: 32'h3E800000, conf: 1'b0});
    start(3'd7, 32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000);
    get_result("tie_n7", 4);
    // Larger value beyond N_eff must be ignored.
    sb.push_back('{idx: 2'd0, val: 32'h3DCCCCCD, conf: 1'b0});
    start(3'd0, 32'h3DCCCCCD, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    get_result("n0_ignore", 1);
  endtask

  task automatic test_ordering;
    Ready = 1'b1;
    sb.push_back('{idx: 2'd2, val: 32'h80000000, conf: 1'b0});
    start(3'd3, 32'h7FC00000, 32'hBF800000, 32'h80000000, 32'h00000000);
    get_result("order_nan_zero", 4);
    sb.push_back('{idx: 2'd3, val: 32'h7F800000, conf: 1'b1});
    start(3'd3, 32'hFF800000, 32'h7FC00001, 32'h3F800000, 32'h7F800000);
    get_result("order_inf", 4);
    sb.push_back('{idx: 2'd0, val: 32'h3E4CCCCD, conf: 1'b0});
    start(3'd3, 32'h3E4CCCCD, 32'h3DCCCCCD, 32'h00000000, 32'hBE4CCCCD);
    get_result("order_first", 4);
  endtask

  task automatic test_backpressure;
    logic [1:0]  i0;
    logic [31:0] m0;
    int bad, seen;
    Ready = 1'b0;
    sb.push_back('{idx: 2'd1, val: 32'h3ECCCCCD, conf: 1'b1});
    start(3'd3, 32'h3DCCCCCD, 32'h3ECCCCCD, 32'h3E4CCCCD, 32'h3E99999A);
    get_result("bp", 4);
    i0 = Index; m0 = MaxVal;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      SmDone = (k == 3);
      Y1 = 32'h3F800000;
      tick(1);
      if (Valid !== 1'b1 || Index !== i0 || MaxVal !== m0) bad++;
    end
    SmDone = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    tests++;
    if (Overrun !== 1'b1) begin
      fails++;
      $display("FAIL bp_overrun: got %b want 1", Overrun);
    end
    Ready = 1'b1;
    tick(1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (Valid === 1'b1) seen++;
      tick(1);
    end
    tests++;
    if (seen != 0 || Overrun !== 1'b1) begin
      fails++;
      $display("FAIL bp_once: got %0d extra valids overrun=%b want 0 and 1", seen, Overrun);
    end
  endtask

  task automatic test_sticky_done;
    int seen;
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    tick(1);
    Ready = 1'b1;
    N = 3'd3; Y0 = 32'h3F000000; Y1 = 32'h3E800000; Y2 = 32'h3E000000; Y3 = 32'h3F400000;
    SmDone = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (Valid === 1'b1) begin
        seen++;
        tests++;
        if (Index !== 2'd3 || MaxVal !== 32'h3F400000) begin
          fails++;
          $display("FAIL sticky_result: got idx=%0d val=%h want 3 3f400000", Index, MaxVal);
        end
      end
    end
    SmDone = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (Valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 1 || Overrun !== 1'b0) begin
      fails++;
      $display("FAIL sticky_once: got %0d results overrun=%b want 1 and 0", seen, Overrun);
    end
  endtask

  task automatic test_reset_midscan;
    int seen;
    Ready = 1'b1;
    start(3'd3, 32'h3DCCCCCD, 32'h3ECCCCCD, 32'h3E4CCCCD, 32'h3E99999A);
    tick(2);
    Reset = 1'b1;
    #1;
    tests++;
    if ({Valid, Index, MaxVal, Busy, Overrun} !== '0) begin
      fails++;
      $display("FAIL midscan_reset: got v=%b i=%0d m=%h b=%b o=%b want all 0",
               Valid, Index, MaxVal, Busy, Overrun);
    end
    tick(1);
    Reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (Valid === 1'b1 || Busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midscan_no_valid: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_thresh;
    Ready = 1'b1;
    sb.push_back('{idx: 2'd1, val: 32'h3ECCCCCD, conf: 1'b1});
    start(3'd3, 32'h3DCCCCCD, 32'h3ECCCCCD, 32'h3E4CCCCD, 32'h00000000);
    get_result("thresh_hi", 4);
    sb.push_back('{idx: 2'd0, val: 32'h3E4CCCCD, conf: 1'b0});
    start(3'd3, 32'h3E4CCCCD, 32'h3DCCCCCD, 32'h00000000, 32'h3DCCCCCD);
    get_result("thresh_lo", 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_clamp();
    test_ordering();
    test_backpressure();
    test_sticky_done();
    test_reset_midscan();
    test_thresh();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results missing, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
